// File: rtl/dp_regmx16_arb_if.sv
// Handshake bundle between the mux-register arbiter, its two producers and its consumer.
// The master side is the producer/consumer environment; the slave side is the arbiter.
interface dp_regmx16_arb_if;
    logic       req_a;
    logic       ack_a;
    logic       req_b;
    logic       ack_b;
    logic [1:0] select;
    logic       data_valid;
    logic       data_take;
    logic       data_src;

    modport master (
        output req_a, req_b, data_take,
        input  ack_a, ack_b, select, data_valid, data_src
    );

    modport slave (
        input  req_a, req_b, data_take,
        output ack_a, ack_b, select, data_valid, data_src
    );
endinterface

// File: rtl/dp_regmx16_arb.sv
// Controller/arbiter for one shared 16-bit mux register used as a one-entry buffer.
// Two producers compete for the load; grants are round-robin or fixed-priority with a starvation guard.
module dp_regmx16_arb #(
    parameter bit          PRI_FIXED = 1'b0,
    parameter int unsigned MAX_WAIT  = 8
) (
    input logic              clk,
    input logic              reset,
    dp_regmx16_arb_if.slave  bus
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic       data_valid_q;
    logic       data_src_q;
    logic       last_grant_q;
    logic [3:0] wait_cnt;

    logic take;
    logic can_load;
    logic grant_a;
    logic grant_b;

    assign take     = data_valid_q & bus.data_take;
    assign can_load = !data_valid_q | take;

    // A load may overlap the consumer's take, giving one word per cycle.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && can_load) begin
            if (bus.req_a && bus.req_b) begin
                if (PRI_FIXED) begin
                    if (wait_cnt == WAIT_LIMIT) grant_b = 1'b1;
                    else                        grant_a = 1'b1;
                end else begin
                    if (last_grant_q) grant_a = 1'b1;
                    else              grant_b = 1'b1;
                end
            end else if (bus.req_a) begin
                grant_a = 1'b1;
            end else if (bus.req_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign bus.ack_a      = grant_a;
    assign bus.ack_b      = grant_b;
    assign bus.select     = {grant_b, grant_a};
    assign bus.data_valid = data_valid_q;
    assign bus.data_src   = data_src_q;

    // last_grant resets to B so that A wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid_q <= 1'b0;
            data_src_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (grant_a || grant_b) begin
            data_valid_q <= 1'b1;
            data_src_q   <= grant_b;
            last_grant_q <= grant_b;
        end else if (take) begin
            data_valid_q <= 1'b0;
        end
    end

    // Counts how often an eligible B lost to A; at the limit B is forced through.
    always_ff @(posedge clk) begin
        if (reset || !PRI_FIXED) begin
            wait_cnt <= 4'd0;
        end else if (grant_b) begin
            wait_cnt <= 4'd0;
        end else if (grant_a && bus.req_b && wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule
